// File: rtl/inst_axi_read_bridge_pkg.sv
// Shared AXI encodings and FSM state type for the instruction-fetch read bridge.
package inst_axi_read_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/inst_axi_read_bridge_if.sv
// AXI read-address and read-data channels as seen by the fetch bridge (master) and memory (slave).
interface inst_axi_read_bridge_if
    import inst_axi_read_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/inst_axi_read_bridge.sv
// Turns a held IF-stage fetch request into one single-beat AXI read and returns the word.
// One transaction in flight; a flush while busy lets the bus finish but suppresses the result.
module inst_axi_read_bridge
    import inst_axi_read_bridge_pkg::*;
#(
    parameter logic [3:0] ARID_VAL = 4'd0,
    parameter int         ADDR_W   = 32,
    parameter int         DATA_W   = 32
)
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_flush,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_data_ok,
    output logic              cpu_err,
    output logic              cpu_stall,
    inst_axi_read_bridge_if.master bus
);

    state_t state;
    state_t state_next;
    logic   err_q;
    logic   discard;
    logic   r_hit;
    logic   issue;
    logic   unused_bits;

    assign bus.arid    = ARID_VAL;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = AXI_SIZE_4B;
    assign bus.arburst = AXI_BURST_INCR;

    assign issue       = (state == ST_IDLE) && cpu_req && !cpu_flush;
    assign r_hit       = (state == ST_DATA) && bus.rvalid && (bus.rid == ARID_VAL);
    assign unused_bits = ^{bus.rlast, cpu_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Beats carrying a foreign ID are still accepted (rready high) but never leave DATA.
    always_comb begin
        state_next  = state;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        cpu_stall   = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_stall = issue;
                if (issue) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus.arvalid = 1'b1;
                cpu_stall   = 1'b1;
                if (bus.arready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                bus.rready = 1'b1;
                cpu_stall  = 1'b1;
                if (r_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_data_ok = !discard && !cpu_flush;
                cpu_err     = !discard && !cpu_flush && err_q;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.araddr <= '0;
            cpu_rdata  <= '0;
            err_q      <= 1'b0;
            discard    <= 1'b0;
        end else begin
            if (issue) begin
                bus.araddr <= {cpu_addr[ADDR_W-1:2], 2'b00};
            end
            if (r_hit) begin
                cpu_rdata <= bus.rdata;
                err_q     <= (bus.rresp != AXI_RESP_OKAY);
            end
            if (state == ST_DONE) begin
                discard <= 1'b0;
            end else if (cpu_flush && ((state == ST_ADDR) || (state == ST_DATA))) begin
                discard <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_axi_read_bridge.sv
// Self-checking bench: directed fetch scenarios with literal expectations, then randomized
// traffic, all compared each cycle against a transaction-level model of the fetch bridge.
module tb_inst_axi_read_bridge;

    logic        clk;
    logic        resetn;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_flush;
    logic [31:0] cpu_rdata;
    logic        cpu_data_ok;
    logic        cpu_err;
    logic        cpu_stall;

    int tests_run;
    int failures;

    inst_axi_read_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_axi_read_bridge #(.ARID_VAL(4'd0), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_flush   (cpu_flush),
        .cpu_rdata   (cpu_rdata),
        .cpu_data_ok (cpu_data_ok),
        .cpu_err     (cpu_err),
        .cpu_stall   (cpu_stall),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic req, input logic [31:0] addr, input logic flush,
                                  input logic arready, input logic rvalid, input logic [3:0] rid,
                                  input logic [31:0] rdata, input logic [1:0] rresp);
        @(posedge clk);
        #1;
        cpu_req     = req;
        cpu_addr    = addr;
        cpu_flush   = flush;
        bus.arready = arready;
        bus.rvalid  = rvalid;
        bus.rid     = rid;
        bus.rdata   = rdata;
        bus.rresp   = rresp;
        bus.rlast   = 1'b1;
    endtask

    // Transaction-level model: a fetch is "in flight" from acceptance until its R beat,
    // and its result is offered the cycle after, unless a flush hit it along the way.
    bit          m_busy;
    bit          m_addr_sent;
    bit          m_deliver;
    bit          m_discard;
    bit          m_err;
    logic [31:0] m_addr;
    logic [31:0] m_rdata;

    always @(negedge clk) begin
        if (!resetn) begin
            m_busy      = 0;
            m_addr_sent = 0;
            m_deliver   = 0;
            m_discard   = 0;
            m_err       = 0;
            m_addr      = '0;
            m_rdata     = '0;
        end else begin
            check_output("model_arvalid", bus.arvalid, m_busy && !m_addr_sent);
            check_output("model_rready", bus.rready, m_busy && m_addr_sent);
            check_output("model_stall", cpu_stall, m_busy || (!m_deliver && cpu_req && !cpu_flush));
            check_output("model_data_ok", cpu_data_ok, m_deliver && !m_discard && !cpu_flush);
            check_output("model_err", cpu_err, m_deliver && !m_discard && !cpu_flush && m_err);
            check_output("model_araddr", bus.araddr, m_addr);
            check_output("model_rdata", cpu_rdata, m_rdata);
            check_output("model_axi_const", {bus.arid, bus.arlen, bus.arsize, bus.arburst},
                         {4'd0, 8'd0, 3'b010, 2'b01});
            if (m_deliver) begin
                m_deliver = 0;
                m_discard = 0;
            end else if (!m_busy) begin
                if (cpu_req && !cpu_flush) begin
                    m_busy      = 1;
                    m_addr_sent = 0;
                    m_addr      = cpu_addr & 32'hFFFF_FFFC;
                end
            end else begin
                if (cpu_flush) m_discard = 1;
                if (!m_addr_sent) begin
                    if (bus.arready) m_addr_sent = 1;
                end else if (bus.rvalid && bus.rid == 4'd0) begin
                    m_rdata   = bus.rdata;
                    m_err     = (bus.rresp != 2'b00);
                    m_busy    = 0;
                    m_deliver = 1;
                end
            end
        end
    end

    int          ok_count;
    bit          stall_seen;
    bit          pending;
    logic        r_req;
    logic [31:0] r_addr;
    logic        r_rvalid;
    logic [3:0]  r_rid;
    logic [1:0]  r_resp;

    initial begin
        tests_run   = 0;
        failures    = 0;
        resetn      = 1'b0;
        cpu_req     = 1'b0;
        cpu_addr    = '0;
        cpu_flush   = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rid     = '0;
        bus.rdata   = '0;
        bus.rresp   = '0;
        bus.rlast   = 1'b1;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_output("reset_arvalid", bus.arvalid, 0);
        check_output("reset_rready", bus.rready, 0);
        check_output("reset_araddr", bus.araddr, 0);
        check_output("reset_rdata", cpu_rdata, 0);
        check_output("reset_data_ok", {cpu_data_ok, cpu_err, cpu_stall}, 0);

        // Zero-wait fetch: data_ok three cycles after the request is seen.
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(c < 3, 32'hBFC0_0000, 1'b0, 1'b1, c == 2, 4'd0, 32'h3C1D_BFC0, 2'b00);
            @(negedge clk);
            check_output("basic_stall", cpu_stall, c < 3);
            check_output("basic_arvalid", bus.arvalid, c == 1);
            check_output("basic_rready", bus.rready, c == 2);
            check_output("basic_data_ok", cpu_data_ok, c == 3);
            if (c == 1) begin
                check_output("basic_araddr", bus.araddr, 32'hBFC0_0000);
                check_output("basic_axi_const", {bus.arlen, bus.arsize, bus.arburst}, {8'd0, 3'd2, 2'd1});
            end
            if (c == 3) check_output("basic_cpu_rdata", cpu_rdata, 32'h3C1D_BFC0);
        end

        // Back-pressure with an unaligned PC: AR waits 5 cycles, R arrives 4 after the handshake.
        ok_count = 0;
        for (int c = 0; c < 13; c++) begin
            apply_stimulus(c <= 10, 32'h0040_0006, 1'b0, c == 6, c == 10, 4'd0, 32'h2402_0001, 2'b00);
            @(negedge clk);
            check_output("bp_stall", cpu_stall, c <= 10);
            check_output("bp_arvalid", bus.arvalid, (c >= 1) && (c <= 6));
            if (c >= 1) check_output("bp_araddr", bus.araddr, 32'h0040_0004);
            if (cpu_data_ok) ok_count++;
            if (c == 11) check_output("bp_cpu_rdata", cpu_rdata, 32'h2402_0001);
        end
        check_output("bp_one_data_ok", ok_count, 1);

        // Flush while waiting for R: result is swallowed, the next fetch starts cleanly.
        for (int c = 0; c < 9; c++) begin
            apply_stimulus((c <= 3) || ((c >= 5) && (c <= 7)), (c <= 3) ? 32'h0000_1000 : 32'h0000_2000,
                           c == 2, 1'b1, (c == 3) || (c == 7), 4'd0,
                           (c == 3) ? 32'hDEAD_BEEF : 32'h1111_2222, 2'b00);
            @(negedge clk);
            check_output("flush_data_ok", cpu_data_ok, c == 8);
            check_output("flush_stall", cpu_stall, (c <= 3) || ((c >= 5) && (c <= 7)));
            check_output("flush_arvalid", bus.arvalid, (c == 1) || (c == 6));
            if (c == 4) check_output("flush_rdata_internal", cpu_rdata, 32'hDEAD_BEEF);
            if (c == 6) check_output("flush_new_araddr", bus.araddr, 32'h0000_2000);
            if (c == 8) check_output("flush_next_rdata", cpu_rdata, 32'h1111_2222);
        end

        // Error response after a foreign-ID beat, then a clean fetch.
        for (int c = 0; c < 9; c++) begin
            apply_stimulus((c <= 3) || ((c >= 5) && (c <= 7)), (c <= 3) ? 32'h0000_3000 : 32'h0000_3004,
                           1'b0, 1'b1, (c == 2) || (c == 3) || (c == 7), (c == 2) ? 4'd5 : 4'd0,
                           (c == 2) ? 32'hBAD0_BAD0 : ((c == 3) ? 32'h0000_000C : 32'h0000_0021),
                           (c == 3) ? 2'b10 : 2'b00);
            @(negedge clk);
            check_output("err_data_ok", cpu_data_ok, (c == 4) || (c == 8));
            check_output("err_flag", cpu_err, c == 4);
            if (c == 4) check_output("err_rdata", cpu_rdata, 32'h0000_000C);
            if (c == 8) check_output("ok_rdata", cpu_rdata, 32'h0000_0021);
        end

        // Asynchronous reset while the address is pending.
        apply_stimulus(1'b1, 32'h0000_4000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 2'b00);
        apply_stimulus(1'b1, 32'h0000_4000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 2'b00);
        @(negedge clk);
        check_output("rst_pre_arvalid", bus.arvalid, 1);
        @(posedge clk);
        #3;
        resetn  = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_output("rst_async_arvalid", bus.arvalid, 0);
        check_output("rst_async_stall", cpu_stall, 0);
        check_output("rst_async_rready", bus.rready, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(c < 3, 32'h0000_5000, 1'b0, 1'b1, c == 2, 4'd0, 32'h0000_5555, 2'b00);
            @(negedge clk);
            check_output("post_rst_arvalid", bus.arvalid, c == 1);
            check_output("post_rst_data_ok", cpu_data_ok, c == 3);
            if (c == 1) check_output("post_rst_araddr", bus.araddr, 32'h0000_5000);
        end

        // Randomized traffic: IF holds req/addr while stalled; slave answers only after its AR.
        ok_count   = 0;
        stall_seen = 0;
        pending    = 0;
        r_req      = 1'b0;
        r_addr     = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!stall_seen) begin
                r_req  = ($urandom_range(0, 3) != 0);
                r_addr = $urandom;
            end
            r_rvalid = pending && ($urandom_range(0, 1) == 1);
            r_rid    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            r_resp   = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
            apply_stimulus(r_req, r_addr, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                           r_rvalid, r_rid, $urandom, r_resp);
            @(negedge clk);
            stall_seen = cpu_stall;
            if (bus.arvalid && bus.arready) pending = 1;
            if (bus.rvalid && bus.rready && bus.rid == 4'd0) pending = 0;
            if (cpu_data_ok) ok_count++;
        end
        check_output("random_activity", ok_count != 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
